// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter with burst limiting and an MMIO write guard for requester 1.
// Optional: define ARB_ROUND_ROBIN_EN for round-robin tie-break in IDLE (default: requester 0 wins).
module dmem_arbiter #(
  parameter int ALEN      = 32,
  parameter int XLEN      = 32,
  parameter int MAX_BURST = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0,
  input  logic            req1,
  input  logic            we0,
  input  logic            we1,
  input  logic [3:0]      be0,
  input  logic [3:0]      be1,
  input  logic [2:0]      funct3_0,
  input  logic [2:0]      funct3_1,
  input  logic [ALEN-1:0] addr0,
  input  logic [ALEN-1:0] addr1,
  input  logic [XLEN-1:0] wdata0,
  input  logic [XLEN-1:0] wdata1,
  output logic            gnt0,
  output logic            gnt1,
  output logic            rvalid0,
  output logic            rvalid1,
  output logic [XLEN-1:0] rdata0,
  output logic [XLEN-1:0] rdata1,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [2:0]      mem_funct3,
  output logic [ALEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            err1
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  state_e     state_q, state_d;
  logic [7:0] burst_q, burst_d;
  logic       rvalid0_q, rvalid0_d;
  logic       rvalid1_q, rvalid1_d;
  logic       pick0, pick1;
  logic       tie_pick1;
  logic       mmio_block;

`ifdef ARB_ROUND_ROBIN_EN
  // rr_q names the requester that wins the next IDLE tie.
  logic rr_q, rr_d;
  assign tie_pick1 = rr_q;

  always_comb begin
    rr_d = rr_q;
    if (gnt0)      rr_d = 1'b1;
    else if (gnt1) rr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= 1'b0;
    else        rr_q <= rr_d;
  end
`else
  assign tie_pick1 = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, otherwise a path that skips it infers a latch.
  always_comb begin
    pick0   = 1'b0;
    pick1   = 1'b0;
    state_d = state_q;
    burst_d = burst_q;
    unique case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          pick1 = tie_pick1;
          pick0 = !tie_pick1;
        end else begin
          pick0 = req0;
          pick1 = req1;
        end
      end
      OWN0: begin
        if (req0 && !(burst_q >= MAX_B && req1)) pick0 = 1'b1;
        else if (req1)                           pick1 = 1'b1;
      end
      OWN1: begin
        if (req1 && !(burst_q >= MAX_B && req0)) pick1 = 1'b1;
        else if (req0)                           pick0 = 1'b1;
      end
      default: ;
    endcase

    // The counter holds grants issued to the current owner, including this cycle's.
    if (pick0) begin
      state_d = OWN0;
      burst_d = (state_q == OWN0 && burst_q < MAX_B) ? burst_q + 8'd1 : 8'd1;
    end else if (pick1) begin
      state_d = OWN1;
      burst_d = (state_q == OWN1 && burst_q < MAX_B) ? burst_q + 8'd1 : 8'd1;
    end else begin
      state_d = IDLE;
      burst_d = 8'd0;
    end
  end

  // Grants are combinational but forced low while reset is held.
  assign gnt0       = pick0 & rst_n;
  assign gnt1       = pick1 & rst_n;
  assign mmio_block = we1 & addr1[ALEN-1];
  assign err1       = gnt1 & mmio_block;

  always_comb begin
    mem_we     = 1'b0;
    mem_be     = '0;
    mem_funct3 = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (gnt0) begin
      mem_we     = we0;
      mem_be     = be0;
      mem_funct3 = funct3_0;
      mem_addr   = addr0;
      mem_wdata  = wdata0;
    end else if (gnt1) begin
      mem_we     = we1 & !mmio_block;
      mem_be     = be1;
      mem_funct3 = funct3_1;
      mem_addr   = addr1;
      mem_wdata  = wdata1;
    end
  end

  assign rvalid0_d = gnt0 & !we0;
  assign rvalid1_d = gnt1 & !we1;

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      burst_q   <= 8'd0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rvalid0_q ? mem_rdata : '0;
  assign rdata1  = rvalid1_q ? mem_rdata : '0;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ALEN, default 32, address width.
REQ-002 SHALL have parameter XLEN, default 32, data width.
REQ-003 SHALL have parameter MAX_BURST, default 8, maximum consecutive grants to one owner while the other requester waits (range 1..255).
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports req0/req1  in  1  access request; requester 0 = CPU load/store, requester 1 = DMA/loader.
REQ-007 SHALL have ports we0/we1  in  1  write (1) / read (0).
REQ-008 SHALL have ports be0/be1  in  4, funct3_0/funct3_1  in  3, addr0/addr1  in  ALEN, wdata0/wdata1  in  XLEN  access attributes.
REQ-009 SHALL have ports gnt0/gnt1  out  1  access accepted and issued to memory this cycle.
REQ-010 SHALL have ports rvalid0/rvalid1  out  1, rdata0/rdata1  out  XLEN  read-return strobe and data.
REQ-011 SHALL have ports mem_we  out  1, mem_be  out  4, mem_funct3  out  3, mem_addr  out  ALEN, mem_wdata  out  XLEN, mem_rdata  in  XLEN  shared data-memory port (1-cycle registered read latency).
REQ-012 SHALL have port err1  out  1  one-cycle pulse: requester-1 write to MMIO region blocked.

Function
REQ-013 SHALL run FSM states IDLE, OWN0, OWN1; at most one gnt per cycle; gnt combinational, same cycle as req.
REQ-014 IDLE: no req -> stay, no gnt; single req -> grant it, go to OWNx; both -> winner per REQ-025, go to OWNwinner.
REQ-015 OWNx with reqx high -> grant x, increment burst counter; reqx low -> go to IDLE (or directly to OWNother if other requesting, granting it this cycle).
REQ-016 When the burst counter reaches MAX_BURST and the other requester is high, the arbiter SHALL grant the other requester that cycle, switch ownership, and clear the counter.
REQ-017 When the burst counter reaches MAX_BURST and the other requester is low, the counter SHALL clear and the owner SHALL keep ownership with no lost cycle.
REQ-018 Ownership change SHALL clear the burst counter; the counter SHALL be 8 bits and never wrap past MAX_BURST.
REQ-019 Memory outputs SHALL carry the granted requester's be/funct3/addr/wdata; mem_we = we of the granted requester; with no grant, mem_we=0 and other mem_* outputs SHALL be 0.
REQ-020 rvalidx SHALL assert exactly one cycle after a granted read by x; rdatax = mem_rdata when rvalidx else 0.
REQ-021 Back-to-back reads SHALL give one rvalid per grant, in order, full throughput (one access per cycle).
REQ-022 A granted write SHALL produce no rvalid.
REQ-023 A requester-1 write with addr[ALEN-1]=1 SHALL still be granted, but mem_we SHALL be 0 and err1 SHALL pulse the same cycle; requester 0 is unrestricted.
REQ-024 A requester dropping req while not granted SHALL lose nothing; no request is queued internally.

Reset
REQ-026 While rst_n=0: FSM=IDLE, burst counter=0, RR pointer=0, gnt0/1=0, rvalid0/1=0, rdata0/1=0, err1=0, mem_we=0, all mem_* outputs 0.
REQ-027 Reset mid-operation SHALL discard any pending read return (no rvalid after reset release).
REQ-028 The first grant after reset release SHALL occur no earlier than the first rising edge with rst_n=1.

Configuration
REQ-025 Tie-break in IDLE SHALL be: with ARB_ROUND_ROBIN_EN defined, the requester not granted most recently wins (RR pointer, reset favours requester 0, updated on every grant); without it, requester 0 always wins.
REQ-029 Without ARB_ROUND_ROBIN_EN, the RR pointer SHALL not be instantiated; REQ-016 burst limiting SHALL apply in both builds.

Verification
REQ-030 req0 read addr 0x100 alone -> gnt0 same cycle, mem_addr=0x100, mem_we=0; rvalid0=1 next cycle, rdata0=mem_rdata.
REQ-031 req0 and req1 both held high from IDLE, MAX_BURST=8 -> 8 gnt0, then gnt1 on the 9th cycle, 8 gnt1, then gnt0; no idle cycle between grants.
REQ-032 req1 write addr 0x8000_0000, wdata 0xF -> gnt1=1, mem_we=0, err1 pulses one cycle; the same write by req0 -> mem_we=1, err1=0.
REQ-033 Simultaneous single-cycle requests from IDLE, repeated 4 times with idle gaps -> without macro gnt0 all 4; with ARB_ROUND_ROBIN_EN gnt0, gnt1, gnt0, gnt1.
REQ-034 Read granted, rst_n pulled low before the next edge -> rvalid0 stays 0, all outputs 0 immediately and after release.
REQ-035 req1 writes 0x20 then reads 0x20 on consecutive cycles -> one write, one read; exactly one rvalid1, one cycle after the read grant.
